// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with an integrated write-pending scoreboard.
//
// Sits between decode/issue and writeback. Issue reads source operands through
// NRD combinational read ports and claims destination registers, which marks
// them busy. Writeback stores results through the single write port, which
// clears the destination's busy bit. A write presented in the current cycle is
// bypassed straight to any read port addressing the same register. A flush
// clears every busy bit at once.
//
// Parameters:
//   XLEN      data width in bits
//   NREGS     number of architectural registers (power of two, >= 2)
//   NRD       number of read ports (1..4)
//   ZERO_REG  1: register 0 reads zero and ignores writes and claims
//   AW        address width, clog2(NREGS) (derived)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous reset, active low
//   rd_addr     read addresses, port i at [i*AW +: AW]
//   rd_data     read data, port i at [i*XLEN +: XLEN]
//   rd_busy     port i source register has a pending, unretired write
//   wr_en       writeback strobe
//   wr_addr     writeback destination
//   wr_data     writeback value
//   claim_en    issue marks claim_addr busy
//   claim_addr  destination being claimed
//   flush       clear all busy bits
//   busy_cnt    number of registers currently busy (registered state only)

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr_ok;
  logic claim_ok;

  // Register 0 swallows writes and claims when it is hardwired to zero.
  assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
  assign claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

  // Next-state: write first, then claim (claim wins on the same address),
  // then flush (overrides any claim, but the data write still lands).
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a missed path would otherwise infer a latch.
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // NOTE: the register array is reset explicitly because software relies on
  // every architectural register reading zero after reset; this keeps the
  // array in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: reset forces zero, then the hardwired zero register, then the
  // same-cycle write bypass, then the array. A register being written this
  // cycle is about to retire, so its busy bit is masked too.
  always_comb begin
    logic [AW-1:0] addr;
    rd_data = '0;
    rd_busy = '0;
    addr    = '0;
    for (int p = 0; p < NRD; p++) begin
      addr = rd_addr[p*AW +: AW];
      if (!rst) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end else if (wr_en && (wr_addr == addr)) begin
        rd_data[p*XLEN +: XLEN] = wr_data;
        rd_busy[p]              = 1'b0;
      end else begin
        rd_data[p*XLEN +: XLEN] = regs_q[addr];
        rd_busy[p]              = busy_q[addr];
      end
    end
  end

  // Population count of the registered busy vector; no bypass of this
  // cycle's claims, writes or flush.
  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy_q[r]};
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters
// (XLEN=32, NREGS=32, NRD=2, ZERO_REG=1). Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 time unit after that.

module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge, then settle 1 unit before driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    claim_en = 1'b1; claim_addr = 5'd6;
    set_rd(5'd5, 5'd6);
    #1;
    n_checks++;
    if (rd_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_rd_forced: got %h expected %h", rd_data, 64'h0);
    end
    tick();
    tick();
    rst = 1'b1;
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_x5: got %h expected %h", rd_data[31:0], 32'h0);
    end
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: got %b expected %b", rd_busy, 2'b00);
    end
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected %0d", busy_cnt, 0);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    tick();
    idle();
    set_rd(5'd3, 5'd0);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_x3: got %h expected %h", rd_data[31:0], 32'h12345678);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL rd_x0: got %h expected %h", rd_data[63:32], 32'h0);
    end
    // Write to x0 is neither bypassed nor stored.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL x0_bypass: got %h expected %h", rd_data[63:32], 32'h0);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL x0_write: got %h expected %h", rd_data[63:32], 32'h0);
    end
  endtask

  task automatic test_bypass();
    idle();
    claim_en = 1'b1; claim_addr = 5'd7;
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    #1;
    n_checks++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL x7_busy: got %b expected %b", rd_busy, 2'b11);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    n_checks++;
    if (rd_data !== 64'hA5A5A5A5_A5A5A5A5) begin
      n_fail++; $display("FAIL bypass_data: got %h expected %h", rd_data, 64'hA5A5A5A5_A5A5A5A5);
    end
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL bypass_busy: got %b expected %b", rd_busy, 2'b00);
    end
    n_checks++;
    if (busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL bypass_cnt_pre: got %0d expected %0d", busy_cnt, 1);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hA5A5A5A5 || busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL bypass_retire: got %h/%0d expected %h/%0d", rd_data[31:0], busy_cnt, 32'hA5A5A5A5, 0);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(5'd9, 5'd3);
    claim_en = 1'b1; claim_addr = 5'd9;
    #1;
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL claim_same_cycle: got %b expected %b", rd_busy, 2'b00);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL claim_x9: got %b/%0d expected %b/%0d", rd_busy, busy_cnt, 2'b01, 1);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h42;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0 || rd_data[31:0] !== 32'h42) begin
      n_fail++; $display("FAIL retire_x9: got %b/%0d/%h expected %b/%0d/%h", rd_busy, busy_cnt, rd_data[31:0], 2'b00, 0, 32'h42);
    end
  endtask

  task automatic test_collision();
    idle();
    set_rd(5'd4, 5'd4);
    claim_en = 1'b1; claim_addr = 5'd4;
    tick();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h11) begin
      n_fail++; $display("FAIL collide_data: got %h expected %h", rd_data[31:0], 32'h11);
    end
    n_checks++;
    if (rd_busy !== 2'b11 || busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL collide_busy: got %b/%0d expected %b/%0d", rd_busy, busy_cnt, 2'b11, 1);
    end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h12;
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    for (int r = 1; r <= 3; r++) begin
      claim_en = 1'b1; claim_addr = AW'(r);
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd3) begin
      n_fail++; $display("FAIL flush_pre_cnt: got %0d expected %0d", busy_cnt, 3);
    end
    flush = 1'b1;
    claim_en = 1'b1; claim_addr = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
    tick();
    idle();
    set_rd(5'd1, 5'd5);
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_busy: got %0d/%b expected %0d/%b", busy_cnt, rd_busy, 0, 2'b00);
    end
    set_rd(5'd2, 5'd3);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h77 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_write: got %h/%b expected %h/%b", rd_data[31:0], rd_busy, 32'h77, 2'b00);
    end
  endtask

  task automatic test_zero_claim();
    idle();
    set_rd(5'd0, 5'd0);
    claim_en = 1'b1; claim_addr = 5'd0;
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL x0_claim: got %0d/%b expected %0d/%b", busy_cnt, rd_busy, 0, 2'b00);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    claim_en = 1'b1; claim_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h55;
    tick();
    idle();
    set_rd(5'd11, 5'd10);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h55 || rd_busy !== 2'b10 || busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL mid_pre: got %h/%b/%0d expected %h/%b/%0d", rd_data[31:0], rd_busy, busy_cnt, 32'h55, 2'b10, 1);
    end
    rst = 1'b0;
    claim_en = 1'b1; claim_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h99;
    #1;
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_busy: got %b expected %b", rd_busy, 2'b00);
    end
    tick();
    rst = 1'b1;
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0 || busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL mid_rst_clear: got %h/%0d expected %h/%0d", rd_data[31:0], busy_cnt, 32'h0, 0);
    end
    set_rd(5'd13, 5'd12);
    #1;
    n_checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_ignore: got %h/%b expected %h/%b", rd_data, rd_busy, 64'h0, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_flush();
    test_zero_claim();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard for the RISC-V core. Provides NRD combinational read ports with same-cycle write bypass, one synchronous write port, and a busy bit per register that the issue stage sets when it claims a destination and writeback clears. Sits between decode/issue (read addresses, claims) and writeback (write port). Register 0 optionally hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1: register 0 reads zero, ignores writes and claims; 0: register 0 is ordinary
- AW, derived, clog2(NREGS), address width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i source has a pending, unretired write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- claim_en  in  1  issue marks claim_addr busy
- claim_addr  in  AW  destination being claimed
- flush  in  1  clear all busy bits (pipeline flush)
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: NREGS x XLEN array, busy vector of NREGS bits.
- Reset (rst=0 at clock edge): all registers to 0, all busy bits to 0. While rst=0, rd_data all zero and rd_busy all zero combinationally.
- Write: wr_en=1 at edge stores wr_data to wr_addr and clears busy[wr_addr]. With ZERO_REG=1 and wr_addr=0 write is dropped.
- Claim: claim_en=1 at edge sets busy[claim_addr]. With ZERO_REG=1 and claim_addr=0 ignored.
- Same-address write and claim in one cycle: claim wins, busy ends 1 (new producer), data still written.
- flush=1: all busy bits 0 at the edge, overriding a same-cycle claim; a same-cycle write still updates data.
- Read port i, combinational, priority: rst=0 -> 0; ZERO_REG=1 and addr 0 -> 0; wr_en=1 and wr_addr==addr -> wr_data (bypass); else array value.
- rd_busy[i]: busy[addr] AND NOT (wr_en and wr_addr==addr); forced 0 for addr 0 when ZERO_REG=1. Claim in current cycle does not affect rd_busy until next cycle.
- busy_cnt: population count of busy vector, registered state only (no bypass); range 0..NREGS (NREGS-1 when ZERO_REG=1).
- All read ports independent; identical addresses on several ports give identical results.

## Timing
- Read latency 0 cycles (address to data/busy combinational, including bypass).
- Write and claim take effect at next rising edge; visible in array/busy the following cycle.
- busy_cnt updates one cycle after the claim/write/flush edge.
- Reset asserted mid-operation: next edge clears everything regardless of wr_en, claim_en, flush.
- No handshake; caller must not claim a register it has not intended to write (no overflow possible, busy is per register).

## Test plan
- Reset: hold rst=0 two cycles with wr_en=1 addr 5 data 0xDEADBEEF -> after release read addr 5 = 0, rd_busy=0, busy_cnt=0.
- Write/read: write x3=0x12345678, next cycle port0 addr 3 = 0x12345678, port1 addr 0 = 0; write x0=0xFFFFFFFF (ZERO_REG=1) -> x0 reads 0.
- Bypass: wr_en=1 addr 7 data 0xA5A5A5A5 with port0 and port1 addr 7 same cycle -> both ports 0xA5A5A5A5, rd_busy 0 even if x7 was busy.
- Scoreboard: claim x9 -> next cycle rd_busy=1 for x9, busy_cnt=1; write x9=0x42 -> next cycle rd_busy=0, busy_cnt=0, data 0x42.
- Collision: x4 busy, same cycle wr_en addr 4 data 0x11 and claim addr 4 -> next cycle x4=0x11, busy=1, busy_cnt=1.
- Flush: claim x1,x2,x3 over three cycles (busy_cnt=3), then flush=1 with claim x5 -> next cycle busy_cnt=0, all rd_busy=0.
